// File: rtl/ram_nxw_2r1w.sv
// Register file of 2**AW words x WIDTH bits: one write port, two independent
// registered read ports with valid flags and write-first bypass.
module ram_nxw_2r1w #(
    parameter int WIDTH = 17,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    wa,
    input  logic             ws,
    input  logic [AW-1:0]    ra1,
    input  logic             rs1,
    input  logic [AW-1:0]    ra2,
    input  logic             rs2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rv1,
    output logic             rv2
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             rv1_q, rv1_d;
    logic             rv2_q, rv2_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (ws) begin
            mem_d[wa] = wd;
        end
    end

    // Read data is forced to zero whenever its valid flag is low.
    always_comb begin
        rd1_d = '0;
        rv1_d = rs1;
        if (rs1) begin
            rd1_d = (ws && (wa == ra1)) ? wd : mem_q[ra1];
        end
        rd2_d = '0;
        rv2_d = rs2;
        if (rs2) begin
            rd2_d = (ws && (wa == ra2)) ? wd : mem_q[ra2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
            rv1_q <= 1'b0;
            rv2_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            rv1_q <= rv1_d;
            rv2_q <= rv2_d;
        end
    end

    assign rd1 = rd1_q;
    assign rd2 = rd2_q;
    assign rv1 = rv1_q;
    assign rv2 = rv2_q;

endmodule

// File: tb/tb_ram_nxw_2r1w.sv
// Directed vector table plus hand-written sequences for ram_nxw_2r1w,
// and a WIDTH=8/AW=4 instance checked against a reference model.
module tb_ram_nxw_2r1w;

    logic        clk;
    logic        rst_n;
    logic [16:0] wd;
    logic [2:0]  wa;
    logic        ws;
    logic [2:0]  ra1;
    logic        rs1;
    logic [2:0]  ra2;
    logic        rs2;
    logic [16:0] rd1;
    logic [16:0] rd2;
    logic        rv1;
    logic        rv2;

    logic        s_rst_n;
    logic [7:0]  s_wd;
    logic [3:0]  s_wa;
    logic        s_ws;
    logic [3:0]  s_ra1;
    logic        s_rs1;
    logic [3:0]  s_ra2;
    logic        s_rs2;
    logic [7:0]  s_rd1;
    logic [7:0]  s_rd2;
    logic        s_rv1;
    logic        s_rv2;

    int checks = 0;
    int errors = 0;

    ram_nxw_2r1w #(.WIDTH(17), .AW(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .wd(wd), .wa(wa), .ws(ws),
        .ra1(ra1), .rs1(rs1), .ra2(ra2), .rs2(rs2),
        .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2)
    );

    ram_nxw_2r1w #(.WIDTH(8), .AW(4)) u_sweep (
        .clk(clk), .rst_n(s_rst_n), .wd(s_wd), .wa(s_wa), .ws(s_ws),
        .ra1(s_ra1), .rs1(s_rs1), .ra2(s_ra2), .rs2(s_rs2),
        .rd1(s_rd1), .rd2(s_rd2), .rv1(s_rv1), .rv2(s_rv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        ws;
        logic [2:0]  wa;
        logic [16:0] wd;
        logic        rs1;
        logic [2:0]  ra1;
        logic        rs2;
        logic [2:0]  ra2;
        logic [16:0] e_rd1;
        logic        e_rv1;
        logic [16:0] e_rd2;
        logic        e_rv2;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic r, logic w, logic [2:0] a, logic [16:0] d,
                                logic s1, logic [2:0] a1, logic s2, logic [2:0] a2,
                                logic [16:0] x1, logic v1, logic [16:0] x2, logic v2);
        vec_t v;
        v.name = name; v.rst_n = r; v.ws = w; v.wa = a; v.wd = d;
        v.rs1 = s1; v.ra1 = a1; v.rs2 = s2; v.ra2 = a2;
        v.e_rd1 = x1; v.e_rv1 = v1; v.e_rd2 = x2; v.e_rv2 = v2;
        vecs.push_back(v);
    endfunction

    // One clock of the main instance: drive on the falling edge, check just after the rising edge.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; ws = v.ws; wa = v.wa; wd = v.wd;
        rs1 = v.rs1; ra1 = v.ra1; rs2 = v.rs2; ra2 = v.ra2;
        @(posedge clk);
        #1;
        checks++;
        if (rd1 !== v.e_rd1 || rv1 !== v.e_rv1 || rd2 !== v.e_rd2 || rv2 !== v.e_rv2) begin
            errors++;
            $display("FAIL %s: got rd1=%0d rv1=%0b rd2=%0d rv2=%0b, expected rd1=%0d rv1=%0b rd2=%0d rv2=%0b",
                     v.name, rd1, rv1, rd2, rv2, v.e_rd1, v.e_rv1, v.e_rd2, v.e_rv2);
        end else begin
            $display("ok   %s: rd1=%0d rv1=%0b rd2=%0d rv2=%0b", v.name, rd1, rv1, rd2, rv2);
        end
    endtask

    task automatic hand(string name, logic r, logic w, logic [2:0] a, logic [16:0] d,
                        logic s1, logic [2:0] a1, logic s2, logic [2:0] a2,
                        logic [16:0] x1, logic v1, logic [16:0] x2, logic v2);
        vec_t v;
        v.name = name; v.rst_n = r; v.ws = w; v.wa = a; v.wd = d;
        v.rs1 = s1; v.ra1 = a1; v.rs2 = s2; v.ra2 = a2;
        v.e_rd1 = x1; v.e_rv1 = v1; v.e_rd2 = x2; v.e_rv2 = v2;
        run_vec(v);
    endtask

    logic [7:0] model [16];

    // One clock of the sweep instance, expected values from the reference model.
    task automatic sweep_cycle(string name, logic w, logic [3:0] a, logic [7:0] d,
                               logic s1, logic [3:0] a1, logic s2, logic [3:0] a2);
        logic [7:0] x1, x2;
        @(negedge clk);
        s_ws = w; s_wa = a; s_wd = d; s_rs1 = s1; s_ra1 = a1; s_rs2 = s2; s_ra2 = a2;
        x1 = 8'd0;
        x2 = 8'd0;
        if (s1) x1 = (w && a == a1) ? d : model[a1];
        if (s2) x2 = (w && a == a2) ? d : model[a2];
        if (w) model[a] = d;
        @(posedge clk);
        #1;
        checks++;
        if (s_rd1 !== x1 || s_rv1 !== s1 || s_rd2 !== x2 || s_rv2 !== s2) begin
            errors++;
            $display("FAIL %s: got rd1=%0h rv1=%0b rd2=%0h rv2=%0b, expected rd1=%0h rv1=%0b rd2=%0h rv2=%0b",
                     name, s_rd1, s_rv1, s_rd2, s_rv2, x1, s1, x2, s2);
        end else begin
            $display("ok   %s: wa=%0d ws=%0b ra1=%0d ra2=%0d rd1=%0h rd2=%0h", name, a, w, a1, a2, s_rd1, s_rd2);
        end
    endtask

    initial begin
        rst_n = 1'b0; ws = 1'b0; wa = '0; wd = '0;
        rs1 = 1'b0; ra1 = '0; rs2 = 1'b0; ra2 = '0;
        s_rst_n = 1'b0; s_ws = 1'b0; s_wa = '0; s_wd = '0;
        s_rs1 = 1'b0; s_ra1 = '0; s_rs2 = 1'b0; s_ra2 = '0;

        // Reset dominates write and reads; then everything reads back zero.
        add("reset0", 0, 1, 0, 20, 1, 0, 1, 0, 0, 0, 0, 0);
        add("reset1", 0, 1, 0, 20, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add($sformatf("rst_readback%0d", i), 1, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0, 1, 0, 1);
        end
        // Basic write then read, then deselect.
        add("basic_wr", 1, 1, 2, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        add("basic_rd", 1, 0, 0, 0, 1, 2, 0, 0, 20, 1, 0, 0);
        add("basic_off", 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        // Write-first bypass on both ports.
        add("byp_pre", 1, 1, 5, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        add("byp_same", 1, 1, 5, 35, 1, 5, 1, 5, 35, 1, 35, 1);
        add("byp_after", 1, 0, 0, 0, 1, 5, 0, 0, 35, 1, 0, 0);
        // Dual-port independence with an all-ones word.
        add("dp_wr1", 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        add("dp_wr6", 1, 1, 6, 131071, 1, 2, 0, 0, 20, 1, 0, 0);
        add("dp_rd", 1, 0, 0, 0, 1, 1, 1, 6, 7, 1, 131071, 1);
        add("dp_swap", 1, 0, 0, 0, 1, 6, 1, 1, 131071, 1, 7, 1);
        add("dp_mixed", 1, 1, 3, 99, 1, 4, 1, 3, 0, 1, 99, 1);
        add("dp_hold", 1, 0, 0, 0, 1, 3, 1, 3, 99, 1, 99, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during active reads discards them and clears the whole array.
        for (int i = 0; i < 8; i++) begin
            hand($sformatf("fill%0d", i), 1, 1, 3'(i), 17'(i + 100), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        hand("fill_rd", 1, 0, 0, 0, 1, 3, 1, 4, 103, 1, 104, 1);
        hand("mid_reset", 0, 1, 0, 55, 1, 7, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            hand($sformatf("post_rst%0d", i), 1, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0, 1, 0, 1);
        end

        // Wider sweep instance against the reference model.
        for (int i = 0; i < 16; i++) model[i] = 8'd0;
        @(negedge clk);
        s_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sweep_cycle($sformatf("sw_wr%0d", i), 1, 4'(i), 8'hA5 ^ 8'(i), 1, 4'(i), 0, 0);
        end
        for (int i = 0; i < 16; i++) begin
            sweep_cycle($sformatf("sw_rd%0d", i), 0, 0, 0, 1, 4'(i), 1, 4'(15 - i));
        end
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a, a1, a2;
            a  = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            sweep_cycle($sformatf("sw_rand%0d", n), 1'($urandom_range(0, 1)), a,
                        8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), a1,
                        1'($urandom_range(0, 1)), a2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
